// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 keyboard decoder producing the 11-bit ps2_key event word
// {toggle, pressed, extended, code}. Raw lines are synchronised, ps2_clk is
// debounced, frames are checked for start/parity/stop/timeout, and the
// resulting bytes are folded into make/break events with E0/F0/E1 prefixes.

`timescale 1ns/1ps

module ps2_key_encoder #(
  parameter real         CLK_FREQ   = 96.0,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int unsigned TimeoutCyc = $rtoi(CLK_FREQ * TIMEOUT_US + 0.5);
  localparam int unsigned FiltW      = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW        = $clog2(TimeoutCyc + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_s;
  logic             data_s;
  logic             clk_filt_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             filt_accept;
  logic             fall;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Two-flop synchronisers; idle-high lines reset high so no edge follows reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // A new clock level is accepted on the FILTER_LEN-th consecutive differing sample
  assign filt_accept = (clk_s != clk_filt_q) && (filt_cnt_q == FiltW'(FILTER_LEN - 1));
  assign fall        = filt_accept && !clk_s;

  // Debounce filter for ps2_clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_s == clk_filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_accept) begin
      clk_filt_q <= clk_s;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FiltW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and inter-edge timeout
  // ---------------------------------------------------------------------------
  logic [1:0]     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           byte_vld_q, byte_vld_d;
  logic           err_q, err_d;
  logic           clr_frame;
  logic [ToW-1:0] to_cnt_q;
  logic           timeout;

  assign timeout = (state_q != StIdle) && !filt_accept &&
                   (to_cnt_q == ToW'(TimeoutCyc - 1));

  // Timeout counter restarts on every accepted edge and is held clear in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (filt_accept || state_q == StIdle || timeout) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + ToW'(1);
    end
  end

  // Frame next-state: sample ps2_data on each filtered falling edge
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    clr_frame  = 1'b0;
    if (timeout) begin
      state_d   = StIdle;
      err_d     = 1'b1;
      clr_frame = 1'b1;
    end else if (fall) begin
      case (state_q)
        StIdle: begin
          if (data_s) begin
            err_d = 1'b1;
          end else begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = data_s;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          // Odd parity over data plus parity bit, and a high stop bit
          if (data_s && (^{shift_q, par_q})) begin
            byte_vld_d = 1'b1;
          end else begin
            err_d     = 1'b1;
            clr_frame = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      byte_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      byte_vld_q <= byte_vld_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte layer: prefixes, Pause swallowing, device responses, event generation
  // ---------------------------------------------------------------------------
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [2:0]  swallow_q, swallow_d;
  logic [10:0] key_q, key_d;
  logic        strobe_q, strobe_d;
  logic        is_resp;

  // shift_q still holds the accepted byte in the cycle after the stop bit
  assign is_resp = (shift_q == 8'hFA) || (shift_q == 8'hAA) || (shift_q == 8'hEE) ||
                   (shift_q == 8'hFE) || (shift_q == 8'hFF) || (shift_q == 8'h00);

  // Byte-layer next-state, rules evaluated in priority order
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    swallow_d = swallow_q;
    key_d     = key_q;
    strobe_d  = 1'b0;
    if (clr_frame) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
    if (byte_vld_q) begin
      if (swallow_q != 3'd0) begin
        swallow_d = swallow_q - 3'd1;
      end else if (shift_q == 8'hE1) begin
        // Remaining 7 bytes of the Pause sequence carry no event
        swallow_d = 3'd7;
        ext_d     = 1'b0;
        brk_d     = 1'b0;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (!ext_q && !brk_q && is_resp) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        key_d    = {~key_q[10], ~brk_q, ext_q, shift_q};
        strobe_d = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  // Byte-layer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      swallow_q <= 3'd0;
      key_q     <= 11'h000;
      strobe_q  <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      swallow_q <= swallow_d;
      key_q     <= key_d;
      strobe_q  <= strobe_d;
    end
  end

  assign ps2_key    = key_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: drives PS/2 frames bit by bit and checks
// the event word, strobe count, error count and stop-bit-to-event latency.

`timescale 1ns/1ps

module tb_ps2_key_encoder;

  localparam int unsigned Filt = 8;
  localparam int unsigned ToUs = 300;  // with CLK_FREQ = 1.0 -> 300-cycle timeout
  localparam int          H    = 30;   // PS/2 half bit period in clk cycles

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  int n_checks = 0;
  int n_errs   = 0;
  int n_strobe = 0;
  int n_ferr   = 0;

  ps2_key_encoder #(
    .CLK_FREQ  (1.0),
    .FILTER_LEN(Filt),
    .TIMEOUT_US(ToUs)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .key_strobe(key_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_strobe) n_strobe++;
    if (frame_err)  n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(fr[i]);
    repeat (2 * H) @(negedge clk);
  endtask

  // Same frame, but the stop bit is hand-driven to measure event latency
  task automatic send_byte_lat(input logic [7:0] b);
    logic [10:0] fr;
    fr = {1'b1, ~(^b), b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
    @(negedge clk) ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (Filt + 2) @(posedge clk);
    #1 check("lat_early", 32'(key_strobe), 32'd0);
    @(posedge clk);
    #1 check("lat_exact", 32'(key_strobe), 32'd1);
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  initial begin
    int ferr0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_key", 32'(ps2_key), 32'h000);
    check("rst_strobe", 32'(key_strobe), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Make A, with latency measurement
    send_byte_lat(8'h1C);
    check("make1_key", 32'(ps2_key), 32'h61C);
    check("make1_cnt", 32'(n_strobe), 32'd1);

    // Same code again: only the toggle differs
    send_byte(8'h1C, 1'b0);
    check("make2_key", 32'(ps2_key), 32'h21C);

    // Break A
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check("brk_key", 32'(ps2_key), 32'h41C);
    check("brk_cnt", 32'(n_strobe), 32'd3);

    // Extended break of up-arrow
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("ext_brk_key", 32'(ps2_key), 32'h175);
    check("ext_brk_cnt", 32'(n_strobe), 32'd4);

    // Pause sequence swallowed, then a normal make
    send_byte(8'hE1, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'hE1, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h77, 1'b0);
    check("pause_cnt", 32'(n_strobe), 32'd4);
    check("pause_key", 32'(ps2_key), 32'h175);
    send_byte(8'h16, 1'b0);
    check("post_pause_key", 32'(ps2_key), 32'h616);

    // Bad parity after E0 clears ext
    ferr0 = n_ferr;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h1C, 1'b1);
    check("par_err", 32'(n_ferr), 32'(ferr0 + 1));
    check("par_cnt", 32'(n_strobe), 32'd5);
    send_byte(8'h74, 1'b0);
    check("par_next_key", 32'(ps2_key), 32'h274);

    // Device response dropped
    send_byte(8'hFA, 1'b0);
    check("resp_cnt", 32'(n_strobe), 32'd6);
    check("resp_key", 32'(ps2_key), 32'h274);

    // 3-cycle glitch on ps2_clk: no edge, no start-bit error, framing intact
    ferr0 = n_ferr;
    @(negedge clk) ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2 * H) @(negedge clk);
    check("glitch_err", 32'(n_ferr), 32'(ferr0));
    send_byte(8'h29, 1'b0);
    check("glitch_key", 32'(ps2_key), 32'h629);

    // Start bit of 1
    ferr0 = n_ferr;
    ps2_bit(1'b1);
    repeat (2 * H) @(negedge clk);
    check("start_err", 32'(n_ferr), 32'(ferr0 + 1));

    // Frame abandoned after 4 data bits: timeout error, ext cleared
    send_byte(8'hE0, 1'b0);
    ferr0 = n_ferr;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (400) @(negedge clk);
    check("timeout_err", 32'(n_ferr), 32'(ferr0 + 1));
    send_byte(8'h1C, 1'b0);
    check("timeout_key", 32'(ps2_key), 32'h21C);
    check("timeout_cnt", 32'(n_strobe), 32'd8);

    // Reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk) reset_n = 1'b0;
    #1 check("midrst_key", 32'(ps2_key), 32'h000);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_cnt", 32'(n_strobe), 32'd8);
    send_byte(8'h1C, 1'b0);
    check("postrst_key", 32'(ps2_key), 32'h61C);
    check("postrst_cnt", 32'(n_strobe), 32'd9);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
